debug_dump_tx: RTL and testbench
================================

// Module: debug_dump_tx
// PURPOSE
//  Host-bound half of the debug UART link. On a dump request from debug_unit, walks PC, register file
//  and the first N_MEM_WORDS data-memory words through the pipeline debug read ports.
//  Serialises them as one framed 8N1 byte stream on debug_out.
//  Counterpart of the instruction-load receiver fed by the board rx pin.
// PARAMETERS
//  NB_DATA      32   debug word width
//  NB_REG       5    register address width
//  NB_ADDR      7    data-memory word address width
//  N_REGISTER   32   registers dumped
//  N_MEM_WORDS  32   memory words dumped, 1..2**NB_ADDR
//  CLKS_PER_BIT 868  clock cycles per UART bit, >=2
// PORTS
//  clock_i                    in  1        single clock
//  reset_i                    in  1        synchronous, active-high
//  dump_start                 in  1        request; sampled only in IDLE
//  data_pc_debug              in  NB_DATA  current PC
//  data_registers_debug       in  NB_DATA  register file read data
//  data_mem_debug             in  NB_DATA  data memory read data
//  addr_reg_debug             out NB_REG   register read address
//  addr_mem_debug             out NB_ADDR  memory read address
//  select_debug_or_wireA      out 1        1 = register port owned by debug
//  select_debug_or_alu_result out 1        1 = memory port owned by debug
//  debug_out                  out 1        UART TX line, idle high
//  dump_busy                  out 1        high from accepted start to end of trailer stop bit
//  dump_done                  out 1        one-cycle pulse when frame complete
// BEHAVIOUR
//  Reset: debug_out=1; dump_busy, dump_done, both selects = 0; addresses = 0; FSM=IDLE; checksum=0.
//  Frame: 0xA5 | PC | R0..R(N_REGISTER-1) | M0..M(N_MEM_WORDS-1) | CHK.
//   - Each word is 4 bytes, LSB first.
//   - CHK = XOR of all payload bytes; header excluded.
//   - Length = 2 + 4*(1+N_REGISTER+N_MEM_WORDS) bytes, 262 at defaults.
//  FSM: IDLE -> HDR -> FETCH -> SEND -> (FETCH | CHK) -> DONE -> IDLE.
//   - IDLE: dump_start=1 -> HDR; busy rises next cycle.
//   - HDR: launch 0xA5; wait for byte accepted-and-finished.
//   - FETCH: drive address and select for word index w.
//     - w=0 PC.
//     - w=1..N_REGISTER: reg w-1.
//     - Then mem w-1-N_REGISTER.
//     - Read data is valid exactly 1 cycle after the address is driven; capture it then into a 32b shift register.
//     - Address and select stay stable through capture.
//   - SEND: issue 4 bytes, LSB first; fold each into CHK on issue.
//   - After the last word -> CHK (send checksum), then DONE.
//   - DONE: one cycle; dump_done=1; busy=0; selects=0.
//  Selects: select_debug_or_wireA=1 only during register FETCH; select_debug_or_alu_result=1 only during memory FETCH.
//   Each drops the cycle after capture.
//  Byte path to uart sub-module: tx_start pulse with tx_byte when tx_busy=0.
//   - tx_busy rises the next cycle.
//   - Each byte: start 0, d0..d7, stop 1, each exactly CLKS_PER_BIT clocks, i.e. 10*CLKS_PER_BIT per byte.
//   - No idle gap beyond one cycle between bytes.
//  Boundaries:
//   - dump_start outside IDLE is ignored, including the DONE cycle.
//   - Word counter stops at last index; no wrap.
//   - N_MEM_WORDS=2**NB_ADDR reads address 2**NB_ADDR-1 last.
//   - reset_i mid-frame: next cycle line=1, selects=0, FSM=IDLE, no dump_done; the truncated byte is abandoned.
//   - Inputs sampled only at capture; changes at other times are ignored.
// STRUCTURE
//  Shared package/header: FRAME_HDR=8'hA5, FSM state encodings, byte count function.
//  Sub-module uart_byte_tx: baud counter, 4-bit bit counter, 10-bit shift register.
//   - Ports tx_start, tx_byte, tx_busy, tx.
//   - Reused by any other TX in the design.
//  Top keeps FSM, word index counter (NB_REG+NB_ADDR+1 bits), byte counter, checksum.
// TESTING  (bench CLKS_PER_BIT=4, UART monitor decodes line)
//  1 Idle after reset, no start -> debug_out=1, busy=0 for 1000 cycles.
//  2 PC=0x00000040, Rk=k*0x01010101, Mk=0xDEAD0000+k; start -> exact 262 bytes.
//    - Bytes begin A5 40 00 00 00.
//    - CHK equals model XOR.
//    - One dump_done pulse at end.
//    - Total 2620*4 + small overhead cycles.
//  3 Read-port check -> each addr held >=2 cycles.
//    - Select high only for its region.
//    - Data changed outside capture cycle does not appear.
//  4 dump_start held high for whole frame and during DONE -> exactly one frame; no restart until start is re-seen in IDLE.
//  5 reset_i at byte 100 mid-bit -> line=1 next cycle, busy=0, no dump_done.
//    - A following start yields a complete correct frame.
//  6 N_MEM_WORDS=128, NB_ADDR=7 -> last mem addr 127.
//    - Frame = 2+4*161 = 646 bytes; addr_mem_debug never wraps to 0 mid-frame.

Source files
------------

// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter.
//   FRAME_HDR    : first byte of every dump frame
//   dump_state_t : frame walker state encoding
//   frame_bytes  : total bytes in one frame for a given register/memory depth
package debug_dump_tx_pkg;

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_FETCH,
      ST_SEND,
      ST_CHK,
      ST_DONE
   } dump_state_t;

   // Header byte + checksum byte + four bytes per word (PC, registers, memory).
   function automatic int unsigned frame_bytes(input int unsigned n_reg,
                                               input int unsigned n_mem);
      return 2 + 4 * (1 + n_reg + n_mem);
   endfunction

endpackage

// File: rtl/debug_dump_tx_uart.sv
// uart_byte_tx: one 8N1 byte transmitter, shared by every TX path in the design.
//   clock_i  in   clock
//   reset_i  in   synchronous active-high reset
//   tx_start in   load tx_byte; honoured only while tx_busy=0
//   tx_byte  in   byte to send, d0 first
//   tx_busy  out  high for exactly 10*CLKS_PER_BIT cycles, from the cycle after tx_start
//   tx       out  serial line, idle high
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_busy,
   output logic       tx
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;

   // Down-counting baud timer; a bit ends on terminal count 0. bit_cnt counts
   // the remaining shifts, so the stop bit is the one that ends at bit_cnt=0.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '1;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_busy  <= 1'b1;
            shreg    <= {1'b1, tx_byte, 1'b0};
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= 4'd9;
         end
      end else if (baud_cnt != '0) begin
         baud_cnt <= baud_cnt - 1'b1;
      end else if (bit_cnt == 4'd0) begin
         tx_busy <= 1'b0;
      end else begin
         shreg    <= {1'b1, shreg[9:1]};
         bit_cnt  <= bit_cnt - 1'b1;
         baud_cnt <= BAUD_RELOAD;
      end
   end

   assign tx = tx_busy ? shreg[0] : 1'b1;

endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: host-bound half of the debug UART link. On dump_start, walks
// PC, the register file and the first N_MEM_WORDS data-memory words through
// the pipeline debug read ports and sends them as one framed 8N1 stream:
//   0xA5 | PC | R0..Rn | M0..Mm | CHK   (words LSB first, CHK = XOR of payload)
// Ports:
//   clock_i, reset_i                 clock, synchronous active-high reset
//   dump_start                       dump request, sampled only in IDLE
//   data_pc_debug                    current PC
//   data_registers_debug             register read data (1 cycle after address)
//   data_mem_debug                   memory read data (1 cycle after address)
//   addr_reg_debug, addr_mem_debug   debug read addresses
//   select_debug_or_wireA            register port owned by debug
//   select_debug_or_alu_result       memory port owned by debug
//   debug_out                        UART TX line, idle high
//   dump_busy                        frame in progress
//   dump_done                        one-cycle pulse at frame end
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for dump_start
// HDR      | launch header byte when the UART is free
// FETCH    | ph0: drive address/select; ph1: capture read data
// SEND     | issue the four bytes of the captured word, fold into CHK
// CHK      | launch checksum, then wait for its stop bit to finish
// DONE     | single-cycle completion pulse
module debug_dump_tx
   import debug_dump_tx_pkg::*;
#(
   parameter int NB_DATA      = 32,
   parameter int NB_REG       = 5,
   parameter int NB_ADDR      = 7,
   parameter int N_REGISTER   = 32,
   parameter int N_MEM_WORDS  = 32,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               dump_start,
   input  logic [NB_DATA-1:0] data_pc_debug,
   input  logic [NB_DATA-1:0] data_registers_debug,
   input  logic [NB_DATA-1:0] data_mem_debug,
   output logic [NB_REG-1:0]  addr_reg_debug,
   output logic [NB_ADDR-1:0] addr_mem_debug,
   output logic               select_debug_or_wireA,
   output logic               select_debug_or_alu_result,
   output logic               debug_out,
   output logic               dump_busy,
   output logic               dump_done
);

   localparam int NB_WIDX = NB_REG + NB_ADDR + 1;
   localparam logic [NB_WIDX-1:0] FIRST_MEM = NB_WIDX'(N_REGISTER + 1);
   localparam logic [NB_WIDX-1:0] LAST_WORD = NB_WIDX'(N_REGISTER + N_MEM_WORDS);

   dump_state_t        state_q, state_n;
   logic               fetch_ph_q, fetch_ph_n;
   logic [NB_WIDX-1:0] word_idx_q, word_idx_n;
   logic [1:0]         byte_cnt_q, byte_cnt_n;
   logic [NB_DATA-1:0] shift_q, shift_n;
   logic [7:0]         chk_q, chk_n;
   logic               chk_sent_q, chk_sent_n;

   logic               tx_start;
   logic [7:0]         tx_byte;
   logic               tx_busy;

   logic               in_reg;
   logic               in_mem;
   logic [NB_DATA-1:0] word_data;

   // Word index 0 is the PC, then registers, then memory.
   assign in_reg = (word_idx_q != '0) && (word_idx_q < FIRST_MEM);
   assign in_mem = (word_idx_q >= FIRST_MEM);

   // Addresses follow the word index, so they are stable for the whole FETCH
   // (address cycle and capture cycle) and never move between words.
   assign addr_reg_debug = in_reg ? NB_REG'(word_idx_q - 1'b1) : '0;
   assign addr_mem_debug = in_mem ? NB_ADDR'(word_idx_q - FIRST_MEM) : '0;

   assign select_debug_or_wireA      = (state_q == ST_FETCH) && in_reg;
   assign select_debug_or_alu_result = (state_q == ST_FETCH) && in_mem;

   assign dump_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign dump_done = (state_q == ST_DONE);

   always_comb begin
      word_data = data_mem_debug;
      if (word_idx_q == '0) begin
         word_data = data_pc_debug;
      end else if (in_reg) begin
         word_data = data_registers_debug;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         fetch_ph_q <= 1'b0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         chk_q      <= '0;
         chk_sent_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         fetch_ph_q <= fetch_ph_n;
         word_idx_q <= word_idx_n;
         byte_cnt_q <= byte_cnt_n;
         shift_q    <= shift_n;
         chk_q      <= chk_n;
         chk_sent_q <= chk_sent_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      fetch_ph_n = fetch_ph_q;
      word_idx_n = word_idx_q;
      byte_cnt_n = byte_cnt_q;
      shift_n    = shift_q;
      chk_n      = chk_q;
      chk_sent_n = chk_sent_q;
      tx_start   = 1'b0;
      tx_byte    = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (dump_start) begin
               state_n    = ST_HDR;
               fetch_ph_n = 1'b0;
               word_idx_n = '0;
               byte_cnt_n = '0;
               chk_n      = '0;
               chk_sent_n = 1'b0;
            end
         end

         // The header is only launched here; the PC fetch overlaps its
         // transmission and SEND waits for the UART to drain.
         ST_HDR: begin
            if (!tx_busy) begin
               tx_start   = 1'b1;
               tx_byte    = FRAME_HDR;
               state_n    = ST_FETCH;
               fetch_ph_n = 1'b0;
            end
         end

         ST_FETCH: begin
            if (!fetch_ph_q) begin
               fetch_ph_n = 1'b1;
            end else begin
               shift_n    = word_data;
               fetch_ph_n = 1'b0;
               byte_cnt_n = '0;
               state_n    = ST_SEND;
            end
         end

         ST_SEND: begin
            if (!tx_busy) begin
               tx_start   = 1'b1;
               tx_byte    = shift_q[7:0];
               shift_n    = {8'h00, shift_q[NB_DATA-1:8]};
               chk_n      = chk_q ^ shift_q[7:0];
               byte_cnt_n = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (word_idx_q == LAST_WORD) begin
                     state_n = ST_CHK;
                  end else begin
                     word_idx_n = word_idx_q + 1'b1;
                     state_n    = ST_FETCH;
                  end
               end
            end
         end

         // Stays here until the checksum stop bit ends so busy covers the
         // whole frame.
         ST_CHK: begin
            if (!tx_busy) begin
               if (!chk_sent_q) begin
                  tx_start   = 1'b1;
                  tx_byte    = chk_q;
                  chk_sent_n = 1'b1;
               end else begin
                  state_n = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            word_idx_n = '0;
            state_n    = ST_IDLE;
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .tx_busy  (tx_busy),
      .tx       (debug_out)
   );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: two instances (32 and 128 memory words) share one
// decoded UART line; expected bytes are queued at stimulus time and popped by
// the line monitor.
module tb_debug_dump_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [31:0] pc_d;
   logic [31:0] rd_reg_a, rd_mem_a, rd_reg_b, rd_mem_b;
   logic [4:0]  ar_a, ar_b;
   logic [6:0]  am_a, am_b;
   logic        sel_r_a, sel_m_a, sel_r_b, sel_m_b;
   logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

   assign pc_d = 32'h0000_0040;

   debug_dump_tx #(.CLKS_PER_BIT(CPB), .N_MEM_WORDS(32)) dut_a (
      .clock_i(clk), .reset_i(rst), .dump_start(start_a),
      .data_pc_debug(pc_d), .data_registers_debug(rd_reg_a), .data_mem_debug(rd_mem_a),
      .addr_reg_debug(ar_a), .addr_mem_debug(am_a),
      .select_debug_or_wireA(sel_r_a), .select_debug_or_alu_result(sel_m_a),
      .debug_out(tx_a), .dump_busy(busy_a), .dump_done(done_a));

   debug_dump_tx #(.CLKS_PER_BIT(CPB), .N_MEM_WORDS(128)) dut_b (
      .clock_i(clk), .reset_i(rst), .dump_start(start_b),
      .data_pc_debug(pc_d), .data_registers_debug(rd_reg_b), .data_mem_debug(rd_mem_b),
      .addr_reg_debug(ar_b), .addr_mem_debug(am_b),
      .select_debug_or_wireA(sel_r_b), .select_debug_or_alu_result(sel_m_b),
      .debug_out(tx_b), .dump_busy(busy_b), .dump_done(done_b));

   initial forever #5 clk = ~clk;

   // Read ports: valid data one cycle after a selected address, junk otherwise.
   always @(posedge clk) begin
      rd_reg_a <= sel_r_a ? {4{3'b000, ar_a}} : $urandom;
      rd_mem_a <= sel_m_a ? (32'hDEAD_0000 + {25'd0, am_a}) : $urandom;
      rd_reg_b <= sel_r_b ? {4{3'b000, ar_b}} : $urandom;
      rd_mem_b <= sel_m_b ? (32'hDEAD_0000 + {25'd0, am_b}) : $urandom;
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic       mon_clr;
   bit         m_act = 0;
   int         m_cnt = 0;
   int         m_bit = 0;
   logic [7:0] m_byte = 8'h00;
   int         rx_cnt = 0;
   int         done_cnt[2] = '{0, 0};
   int         run_r[2], run_m[2], nreg[2], nmem[2], last_mem[2], perr[2];
   logic [4:0] held_r[2];
   logic [6:0] held_m[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mon_step();
      logic       line, sr, sm;
      logic [4:0] ar;
      logic [6:0] am;
      line = tx_a & tx_b;
      if (done_a) done_cnt[0]++;
      if (done_b) done_cnt[1]++;
      if (mon_clr) begin
         m_act = 0;
         for (int i = 0; i < 2; i++) begin
            run_r[i] = 0; run_m[i] = 0; nreg[i] = 0; nmem[i] = 0;
            last_mem[i] = -1; perr[i] = 0;
         end
      end else begin
         if (!m_act) begin
            if (!line) begin
               m_act = 1; m_cnt = CPB + 1; m_bit = 0;
            end
         end else if (m_cnt != 0) begin
            m_cnt--;
         end else if (m_bit < 8) begin
            m_byte[m_bit] = line;
            m_bit++;
            m_cnt = CPB - 1;
         end else begin
            m_act = 0;
            check("stop_bit", line, 1);
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL extra_byte: got %0h expected none", m_byte);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (m_byte !== e) begin
                  n_bad++;
                  $display("FAIL byte%0d: got %0h expected %0h", rx_cnt, m_byte, e);
               end
            end
            rx_cnt++;
         end
         for (int i = 0; i < 2; i++) begin
            sr = (i == 1) ? sel_r_b : sel_r_a;
            sm = (i == 1) ? sel_m_b : sel_m_a;
            ar = (i == 1) ? ar_b : ar_a;
            am = (i == 1) ? am_b : am_a;
            if (sr && sm) perr[i]++;
            if (sr) begin
               if (run_r[i] == 0) begin
                  held_r[i] = ar;
                  if (ar != 5'(nreg[i])) perr[i]++;
               end else if (ar != held_r[i]) perr[i]++;
               run_r[i]++;
            end else if (run_r[i] != 0) begin
               if (run_r[i] < 2) perr[i]++;
               nreg[i]++;
               run_r[i] = 0;
            end
            if (sm) begin
               if (run_m[i] == 0) begin
                  held_m[i] = am;
                  last_mem[i] = int'(am);
                  if (am != 7'(nmem[i])) perr[i]++;
               end else if (am != held_m[i]) perr[i]++;
               run_m[i]++;
            end else if (run_m[i] != 0) begin
               if (run_m[i] < 2) perr[i]++;
               nmem[i]++;
               run_m[i] = 0;
            end
         end
      end
   endtask

   // PC=0x40, Rk=k*0x01010101 (XOR of its four bytes is 0), Mk=0xDEAD0000+k;
   // by hand the checksum is 0x40 for both memory depths.
   task automatic build_frame(input int n_mem);
      logic [7:0]  chk;
      logic [31:0] w;
      chk = 8'h00;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 33 + n_mem; k++) begin
         if (k == 0)       w = 32'h0000_0040;
         else if (k <= 32) w = {4{8'(k - 1)}};
         else              w = 32'hDEAD_0000 + 32'(k - 33);
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            chk = chk ^ w[8*b +: 8];
         end
      end
      exp_q.push_back(chk);
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick(1);
      mon_clr = 1'b0;
   endtask

   task automatic wait_done(input int which, input int budget, output int cycles, output bit ok);
      ok = 0;
      for (cycles = 1; cycles <= budget; cycles++) begin
         tick(1);
         if ((which == 1) ? done_b : done_a) begin
            ok = 1;
            return;
         end
      end
   endtask

   task automatic post_frame_checks(input int which, input int n_mem, input int len,
                                    input int rx0, input int d0);
      tick(6);
      check("queue_empty", exp_q.size(), 0);
      check("frame_len", rx_cnt - rx0, len);
      check("done_pulses", done_cnt[which] - d0, 1);
      check("port_errs", perr[which], 0);
      check("reg_fetches", nreg[which], 32);
      check("mem_fetches", nmem[which], n_mem);
      check("last_mem_addr", last_mem[which], n_mem - 1);
   endtask

   task automatic run_frame(input int which, input int n_mem, input int len);
      int rx0, d0, cyc;
      bit ok;
      clear_mon();
      build_frame(n_mem);
      rx0 = rx_cnt;
      d0  = done_cnt[which];
      if (which == 1) start_b = 1'b1; else start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      start_b = 1'b0;
      wait_done(which, len * (10 * CPB + 1) + 100, cyc, ok);
      check("frame_done", ok, 1);
      check("frame_cycles_lo", (cyc + 1) >= len * 10 * CPB, 1);
      check("frame_cycles_hi", (cyc + 1) <= len * (10 * CPB + 1) + 16, 1);
      post_frame_checks(which, n_mem, len, rx0, d0);
   endtask

   task automatic stimulus();
      int  bad, rx0, d0, cyc;
      bit  ok;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mon_clr = 1'b1;
      tick(3);
      check("rst_line", tx_a, 1);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_sel_reg", sel_r_a, 0);
      check("rst_sel_mem", sel_m_a, 0);
      check("rst_addr_reg", ar_a, 0);
      check("rst_addr_mem", am_a, 0);
      rst = 1'b0; mon_clr = 1'b0;

      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || tx_b !== 1'b1 || busy_b !== 1'b0) bad++;
      end
      check("idle_1000", bad, 0);

      run_frame(0, 32, 262);

      // dump_start held through the frame and the DONE cycle.
      clear_mon();
      build_frame(32);
      rx0 = rx_cnt; d0 = done_cnt[0];
      start_a = 1'b1;
      wait_done(0, 262 * 41 + 100, cyc, ok);
      start_a = 1'b0;
      check("held_done", ok, 1);
      post_frame_checks(0, 32, 262, rx0, d0);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (busy_a !== 1'b0) bad++;
      end
      check("held_no_restart", bad, 0);
      check("held_single_done", done_cnt[0] - d0, 1);

      // Reset in the middle of byte 100.
      clear_mon();
      build_frame(32);
      rx0 = rx_cnt; d0 = done_cnt[0];
      start_a = 1'b1;
      tick(1);
      start_a = 1'b0;
      ok = 0;
      for (int i = 0; i < 100 * 41 + 200; i++) begin
         tick(1);
         if (rx_cnt - rx0 >= 100) begin
            ok = 1;
            break;
         end
      end
      check("reach_byte100", ok, 1);
      tick(15);
      rst = 1'b1; mon_clr = 1'b1;
      exp_q.delete();
      tick(1);
      check("mid_rst_line", tx_a, 1);
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_sel_reg", sel_r_a, 0);
      check("mid_rst_sel_mem", sel_m_a, 0);
      rst = 1'b0;
      tick(1);
      mon_clr = 1'b0;
      tick(50);
      check("mid_rst_no_done", done_cnt[0] - d0, 0);
      check("mid_rst_idle", busy_a, 0);
      run_frame(0, 32, 262);

      run_frame(1, 128, 646);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            mon_step();
         end
         stimulus();
      join_any
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
